// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: ID-stage immediate decoder with format tag, PC-relative
// target precompute and a 2-entry skid buffer on a valid/ready output.
//
// Parameters:
//   XLEN        32 or 64; any other value stops elaboration
// Ports:
//   clk, rst    clock; asynchronous active-low reset
//   flush       drops both buffered entries and any same-cycle accept
//   in_valid    instruction presented
//   in_ready    registered; low only while the skid entry is occupied
//   in_instr    32-bit instruction word
//   in_pc       PC of the instruction
//   out_valid   result held on out_*
//   out_ready   consumer accepts the result
//   out_imm     sign/zero-extended immediate
//   out_fmt     0 I, 1 S, 2 B, 3 U, 4 J, 5 Z, 6 SH, 7 none
//   out_target  pc + imm for B, J and AUIPC, else 0
//   out_pc      PC carried through
//   out_illegal in_instr[1:0] != 2'b11
// Build option: define IMMGEN_ZICSR_EN to decode CSR*I zimm as format Z.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_U  = 3'd3;
    localparam logic [2:0] FMT_J  = 3'd4;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] FMT_Z  = 3'd5;
`endif
    localparam logic [2:0] FMT_SH = 3'd6;
    localparam logic [2:0] FMT_NO = 3'd7;

    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_OP32    = 5'b01110;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
`endif

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
        logic            ill;
    } entry_t;

    localparam entry_t RST_ENTRY = '{
        imm: '0, fmt: FMT_NO, tgt: '0, pc: '0, ill: 1'b0
    };

    logic [4:0]  opc;
    logic [31:0] imm32;
    logic [XLEN-1:0] imm_x;
    logic [2:0]  fmt;
    logic        pcrel;
    logic        legal;
    logic        sh_hi;
    entry_t      dec;

    // Every immediate is first formed as a 32-bit value that is already
    // correct when read as signed; widening to XLEN is then one sign
    // extension (shamt/zimm are small positives, so that is a zext too).
    always_comb begin
        opc   = in_instr[6:2];
        legal = (in_instr[1:0] == 2'b11);
        sh_hi = (XLEN == 64) && (opc == OPC_OPIMM) && in_instr[25];
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt   = FMT_I;
        pcrel = 1'b0;
        case (opc)
            OPC_STORE: begin
                imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                         in_instr[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                fmt   = FMT_B;
                pcrel = 1'b1;
            end
            OPC_LUI: begin
                imm32 = {in_instr[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_AUIPC: begin
                imm32 = {in_instr[31:12], 12'b0};
                fmt   = FMT_U;
                pcrel = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{11{in_instr[31]}}, in_instr[31],
                         in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
                fmt   = FMT_J;
                pcrel = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                // funct3 001/101 are the shifts; funct7 is not immediate
                if (in_instr[13:12] == 2'b01) begin
                    imm32 = {26'b0, sh_hi, in_instr[24:20]};
                    fmt   = FMT_SH;
                end
            end
            OPC_OP, OPC_OP32: begin
                imm32 = '0;
                fmt   = FMT_NO;
            end
`ifdef IMMGEN_ZICSR_EN
            OPC_SYSTEM: begin
                if (in_instr[14]) begin
                    imm32 = {27'b0, in_instr[19:15]};
                    fmt   = FMT_Z;
                end
            end
`endif
            default: ;
        endcase
        if (!legal) begin
            imm32 = '0;
            fmt   = FMT_NO;
            pcrel = 1'b0;
        end
        imm_x   = XLEN'($signed(imm32));
        dec.imm = imm_x;
        dec.fmt = fmt;
        dec.tgt = pcrel ? (in_pc + imm_x) : '0;
        dec.pc  = in_pc;
        dec.ill = !legal;
    end

    entry_t out_q, out_d, sk_q, sk_d;
    logic   out_v_q, out_v_d, sk_v_q, sk_v_d;
    logic   acc, drain;

    assign acc   = in_valid && !sk_v_q;
    assign drain = out_v_q && out_ready;

    // sk_v_q implies OUT is full, and it blocks accept, so an accept
    // together with a drain always has an empty skid entry.
    always_comb begin
        out_d   = out_q;
        sk_d    = sk_q;
        out_v_d = out_v_q;
        sk_v_d  = sk_v_q;
        if (flush) begin
            out_v_d = 1'b0;
            sk_v_d  = 1'b0;
        end else if (drain) begin
            if (sk_v_q) begin
                out_d  = sk_q;
                sk_v_d = 1'b0;
            end else if (acc) begin
                out_d = dec;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (acc) begin
            if (!out_v_q) begin
                out_d   = dec;
                out_v_d = 1'b1;
            end else begin
                sk_d   = dec;
                sk_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= RST_ENTRY;
            sk_q    <= RST_ENTRY;
            out_v_q <= 1'b0;
            sk_v_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            sk_q    <= sk_d;
            out_v_q <= out_v_d;
            sk_v_q  <= sk_v_d;
        end
    end

    assign in_ready    = !sk_v_q;
    assign out_valid   = out_v_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.tgt;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table, directed buffering sequences and
// randomized traffic against a reference model, for XLEN 32 and 64.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc64 = '0;
    logic        out_ready = 1'b0;

    logic        i32_ready, o32_valid, o32_ill;
    logic [31:0] o32_imm, o32_tgt, o32_pc;
    logic [2:0]  o32_fmt;
    logic        i64_ready, o64_valid, o64_ill;
    logic [63:0] o64_imm, o64_tgt, o64_pc;
    logic [2:0]  o64_fmt;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(i32_ready),
        .in_instr(in_instr), .in_pc(in_pc64[31:0]),
        .out_valid(o32_valid), .out_ready(out_ready),
        .out_imm(o32_imm), .out_fmt(o32_fmt),
        .out_target(o32_tgt), .out_pc(o32_pc),
        .out_illegal(o32_ill)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(i64_ready),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(o64_valid), .out_ready(out_ready),
        .out_imm(o64_imm), .out_fmt(o64_fmt),
        .out_target(o64_tgt), .out_pc(o64_pc),
        .out_illegal(o64_ill)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int delivered = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] imm;
        int          fmt;
        logic [63:0] tgt;
        bit          ill;
    } exp_t;

    function automatic longint sx(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1)))
            return v - (longint'(1) << n);
        return v;
    endfunction

    // Reference decode from the field-layout rules, using integers.
    function automatic exp_t model(input logic [31:0] i,
                                   input logic [63:0] pc,
                                   input bit x64);
        exp_t   e;
        longint v;
        int     f3;
        bit     pcrel;
        f3    = int'(i[14:12]);
        e.ill = (i[1:0] != 2'b11);
        v     = 0;
        e.fmt = 7;
        pcrel = 0;
        if (!e.ill) begin
            case (i[6:2])
                5'b01000: begin
                    v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
                    e.fmt = 1;
                end
                5'b11000: begin
                    v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                         + longint'(i[30:25]) * 32
                         + longint'(i[11:8]) * 2, 13);
                    e.fmt = 2;
                    pcrel = 1;
                end
                5'b01101, 5'b00101: begin
                    v = sx(longint'(i[31:12]) * 4096, 32);
                    e.fmt = 3;
                    pcrel = (i[6:2] == 5'b00101);
                end
                5'b11011: begin
                    v = sx(longint'(i[31]) * (1 << 20)
                         + longint'(i[19:12]) * 4096
                         + longint'(i[20]) * 2048
                         + longint'(i[30:21]) * 2, 21);
                    e.fmt = 4;
                    pcrel = 1;
                end
                5'b00100, 5'b00110: begin
                    if (f3 == 1 || f3 == 5) begin
                        if (x64 && i[6:2] == 5'b00100)
                            v = longint'(i[25:20]);
                        else
                            v = longint'(i[24:20]);
                        e.fmt = 6;
                    end else begin
                        v = sx(longint'(i[31:20]), 12);
                        e.fmt = 0;
                    end
                end
                5'b01100, 5'b01110: begin
                    v = 0;
                    e.fmt = 7;
                end
`ifdef IMMGEN_ZICSR_EN
                5'b11100: begin
                    if (f3 >= 4) begin
                        v = longint'(i[19:15]);
                        e.fmt = 5;
                    end else begin
                        v = sx(longint'(i[31:20]), 12);
                        e.fmt = 0;
                    end
                end
`endif
                default: begin
                    v = sx(longint'(i[31:20]), 12);
                    e.fmt = 0;
                end
            endcase
        end
        e.imm = 64'(v);
        e.tgt = pcrel ? pc + e.imm : 64'd0;
        if (!x64) begin
            e.imm = {32'd0, e.imm[31:0]};
            e.tgt = {32'd0, e.tgt[31:0]};
        end
        return e;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    item_t q32[$];
    item_t q64[$];

    task automatic cmp32(input string p, input item_t it);
        exp_t e;
        e = model(it.instr, it.pc, 1'b0);
        chk({p, "_imm32"}, 64'(o32_imm), e.imm);
        chk({p, "_fmt32"}, 64'(o32_fmt), 64'(e.fmt));
        chk({p, "_tgt32"}, 64'(o32_tgt), e.tgt);
        chk({p, "_pc32"}, 64'(o32_pc), {32'd0, it.pc[31:0]});
        chk({p, "_ill32"}, 64'(o32_ill), 64'(e.ill));
    endtask

    task automatic cmp64(input string p, input item_t it);
        exp_t e;
        e = model(it.instr, it.pc, 1'b1);
        chk({p, "_imm64"}, o64_imm, e.imm);
        chk({p, "_fmt64"}, 64'(o64_fmt), 64'(e.fmt));
        chk({p, "_tgt64"}, o64_tgt, e.tgt);
        chk({p, "_pc64"}, o64_pc, it.pc);
        chk({p, "_ill64"}, 64'(o64_ill), 64'(e.ill));
    endtask

    // Occupancy model: items accepted minus items delivered.
    task automatic sb_eval();
        item_t it;
        chk("occ_valid32", 64'(o32_valid), 64'(q32.size() > 0));
        chk("occ_ready32", 64'(i32_ready), 64'(q32.size() < 2));
        chk("occ_valid64", 64'(o64_valid), 64'(q64.size() > 0));
        chk("occ_ready64", 64'(i64_ready), 64'(q64.size() < 2));
        if (flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (o32_valid && out_ready && q32.size() > 0) begin
                it = q32.pop_front();
                cmp32("sb", it);
                delivered++;
            end
            if (o64_valid && out_ready && q64.size() > 0) begin
                it = q64.pop_front();
                cmp64("sb", it);
            end
            if (in_valid && i32_ready) q32.push_back('{in_instr, in_pc64});
            if (in_valid && i64_ready) q64.push_back('{in_instr, in_pc64});
        end
    endtask

    // Inputs are set just after a rising edge; step checks at the
    // falling edge and returns just after the next rising edge.
    task automatic step();
        @(negedge clk);
        sb_eval();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t tv[13];

    logic [6:0] opcodes[13];

    initial begin
        int base;
        bit acc;
        opcodes = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                    7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        tv[0]  = '{32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 3'd2, 32'hFC, 1'b0};
        tv[1]  = '{32'h001000EF, 32'h0, 32'h800, 3'd4, 32'h800, 1'b0};
        tv[2]  = '{32'hFFFFF0B7, 32'h40, 32'hFFFFF000, 3'd3, 32'h0, 1'b0};
        tv[3]  = '{32'h01F09093, 32'h0, 32'd31, 3'd6, 32'h0, 1'b0};
        tv[4]  = '{32'h4030D093, 32'h0, 32'd3, 3'd6, 32'h0, 1'b0};
`ifdef IMMGEN_ZICSR_EN
        tv[5]  = '{32'h300FD073, 32'h10, 32'h1F, 3'd5, 32'h0, 1'b0};
`else
        tv[5]  = '{32'h300FD073, 32'h10, 32'h300, 3'd0, 32'h0, 1'b0};
`endif
        tv[6]  = '{32'h00000000, 32'h200, 32'h0, 3'd7, 32'h0, 1'b1};
        tv[7]  = '{32'hFE20AE23, 32'h0, 32'hFFFFFFFC, 3'd1, 32'h0, 1'b0};
        tv[8]  = '{32'h00001097, 32'h1000, 32'h1000, 3'd3, 32'h2000, 1'b0};
        tv[9]  = '{32'h002081B3, 32'h4, 32'h0, 3'd7, 32'h0, 1'b0};
        tv[10] = '{32'hFFC08067, 32'h8, 32'hFFFFFFFC, 3'd0, 32'h0, 1'b0};
        tv[11] = '{32'h001000EF, 32'hFFFFF900, 32'h800, 3'd4, 32'h100, 1'b0};
        tv[12] = '{32'h03F09093, 32'h0, 32'd31, 3'd6, 32'h0, 1'b0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o32_valid), 64'd0);
        chk("rst_ready", 64'(i32_ready), 64'd1);
        chk("rst_fmt", 64'(o32_fmt), 64'd7);
        chk("rst_imm", 64'(o32_imm), 64'd0);
        chk("rst_tgt64", o64_tgt, 64'd0);
        chk("rst_ill", 64'(o32_ill), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, one instruction at a time
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            item_t it;
            in_valid = 1'b1;
            in_instr = tv[k].instr;
            in_pc64  = {32'd0, tv[k].pc};
            it = '{tv[k].instr, {32'd0, tv[k].pc}};
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("tv%0d_valid", k), 64'(o32_valid), 64'd1);
            chk($sformatf("tv%0d_imm", k), 64'(o32_imm), 64'(tv[k].imm));
            chk($sformatf("tv%0d_fmt", k), 64'(o32_fmt), 64'(tv[k].fmt));
            chk($sformatf("tv%0d_tgt", k), 64'(o32_tgt), 64'(tv[k].tgt));
            chk($sformatf("tv%0d_pc", k), 64'(o32_pc), 64'(tv[k].pc));
            chk($sformatf("tv%0d_ill", k), 64'(o32_ill), 64'(tv[k].ill));
            cmp64($sformatf("tv%0d", k), it);
            if (k == 2)
                chk("lui64_imm", o64_imm, 64'hFFFFFFFFFFFFF000);
            if (k == 12)
                chk("slli64_shamt", o64_imm, 64'd63);
            @(posedge clk);
            #1;
        end

        // Reset while two items are buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h001000EF;
        in_pc64   = 64'h20;
        step();
        in_instr  = 32'hFE000EE3;
        step();
        in_valid  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(o32_valid), 64'd0);
        chk("midrst_ready", 64'(i32_ready), 64'd1);
        chk("midrst_fmt", 64'(o32_fmt), 64'd7);
        chk("midrst_valid64", 64'(o64_valid), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        step();

        // Backpressure: three items against a stalled consumer
        out_ready = 1'b0;
        base = delivered;
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc64  = 64'h300;
        step();
        in_instr = 32'h00A00113;
        in_pc64  = 64'h304;
        step();
        chk("bp_ready_low", 64'(i32_ready), 64'd0);
        in_instr = 32'h00F00193;
        in_pc64  = 64'h308;
        step();
        step();
        chk("bp_ready_held", 64'(i32_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            acc = in_valid && i32_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_in_taken", 64'(in_valid), 64'd0);
        chk("bp_delivered", 64'(delivered - base), 64'd3);
        chk("bp_empty", 64'(q32.size()), 64'd0);

        // Throughput: 20 back-to-back items
        base = delivered;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_instr = 32'h00000013 | (32'(k) << 20);
            in_pc64  = 64'h400 + 64'(4 * k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("tp_delivered", 64'(delivered - base), 64'd20);

        // Flush with two buffered items and a presented input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        step();
        in_instr  = 32'h00200093;
        step();
        flush     = 1'b1;
        in_instr  = 32'h00300093;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl2_valid", 64'(o32_valid), 64'd0);
        chk("fl2_ready", 64'(i32_ready), 64'd1);
        // Flush with one buffered item; the same-cycle accept is dropped
        in_valid  = 1'b1;
        in_instr  = 32'h00400093;
        step();
        flush     = 1'b1;
        in_instr  = 32'h00500093;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl1_valid", 64'(o32_valid), 64'd0);
        chk("fl1_ready", 64'(i32_ready), 64'd1);
        step();
        chk("fl1_dropped", 64'(o32_valid), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = opcodes[$urandom_range(0, 12)];
            if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
            in_instr  = w;
            in_pc64   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", 64'(q32.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
